// File: rtl/atm_session_if.sv
// Front-end <-> session controller bundle: card/keypad requests in, mechanism commands and status out.
// Macro-independent; the controller decides which fields carry meaning in each state.
interface atm_session_if #(
   parameter int BAL_W = 16,
   parameter int PIN_W = 16
);
   logic             card_in;
   logic             pin_valid;
   logic [PIN_W-1:0] pin_code;
   logic [PIN_W-1:0] card_pin;
   logic             op_valid;
   logic [1:0]       op_code;
   logic [BAL_W-1:0] amount;
   logic             lang_valid;
   logic [1:0]       lang_sel;

   logic             ready;
   logic [2:0]       state;
   logic             cash_valid;
   logic [BAL_W-1:0] cash_amount;
   logic             deposit_done;
   logic             balance_valid;
   logic [BAL_W-1:0] balance;
   logic             card_eject;
   logic             card_retain;
   logic             error;
   logic [2:0]       err_code;
   logic [1:0]       language;

   modport master (
      output card_in, pin_valid, pin_code, card_pin, op_valid, op_code, amount,
             lang_valid, lang_sel,
      input  ready, state, cash_valid, cash_amount, deposit_done, balance_valid,
             balance, card_eject, card_retain, error, err_code, language
   );

   modport slave (
      input  card_in, pin_valid, pin_code, card_pin, op_valid, op_code, amount,
             lang_valid, lang_sel,
      output ready, state, cash_valid, cash_amount, deposit_done, balance_valid,
             balance, card_eject, card_retain, error, err_code, language
   );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: PIN check with retry limit, balance/withdraw/deposit/eject, idle timeout.
// Optional per-session withdrawal cap enabled by defining ATM_SESSION_LIMIT_EN.
module atm_session_ctrl #(
   parameter int BAL_W       = 16,
   parameter int PIN_W       = 16,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 255,
   parameter int INIT_BAL    = 1000,
   parameter int WD_LIMIT    = 500
) (
   input  logic         clk,
   input  logic         reset,
   atm_session_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PIN    = 3'd1;
   localparam logic [2:0] S_MENU   = 3'd2;
   localparam logic [2:0] S_EJECT  = 3'd3;
   localparam logic [2:0] S_RETAIN = 3'd4;
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [2:0]       state_q;
   logic [3:0]       tries_q;
   logic [TW-1:0]    timer_q;
   logic [BAL_W-1:0] bal_q;
   logic [BAL_W-1:0] cash_amt_q;
   logic [2:0]       err_code_q;
   logic [1:0]       lang_q;
   logic             cash_vld_q, dep_done_q, bal_vld_q, eject_q, retain_q, error_q;

   logic             in_session, pin_acc, op_acc, lang_acc, any_acc, expire, pin_match;
   logic [BAL_W:0]   dep_sum;
   logic             limit_hit;

   assign in_session = (state_q == S_PIN || state_q == S_MENU) && bus.card_in;
   assign pin_acc    = in_session && (state_q == S_PIN) && bus.pin_valid;
   assign op_acc     = in_session && (state_q == S_MENU) && bus.op_valid;
   assign lang_acc   = in_session && bus.lang_valid;
   assign any_acc    = pin_acc || op_acc || lang_acc;
   // Timer holds idle cycles already elapsed; this edge is the TIMEOUT_CYC-th idle one.
   assign expire     = in_session && !any_acc && (timer_q == TW'(TIMEOUT_CYC - 1));
   assign pin_match  = (PIN_W'(bus.pin_code) == PIN_W'(bus.card_pin));
   assign dep_sum    = {1'b0, bal_q} + {1'b0, bus.amount};

`ifdef ATM_SESSION_LIMIT_EN
   logic [BAL_W:0] wd_total_q;
   assign limit_hit = (wd_total_q + {1'b0, bus.amount}) > (BAL_W+1)'(WD_LIMIT);
`else
   assign limit_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tries_q    <= '0;
         timer_q    <= '0;
         bal_q      <= BAL_W'(INIT_BAL);
         cash_amt_q <= '0;
         err_code_q <= '0;
         lang_q     <= '0;
         cash_vld_q <= 1'b0;
         dep_done_q <= 1'b0;
         bal_vld_q  <= 1'b0;
         eject_q    <= 1'b0;
         retain_q   <= 1'b0;
         error_q    <= 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
         wd_total_q <= '0;
`endif
      end else begin
         cash_vld_q <= 1'b0;
         dep_done_q <= 1'b0;
         bal_vld_q  <= 1'b0;
         eject_q    <= 1'b0;
         retain_q   <= 1'b0;
         error_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tries_q <= '0;
               timer_q <= '0;
`ifdef ATM_SESSION_LIMIT_EN
               wd_total_q <= '0;
`endif
               if (bus.card_in) begin
                  state_q    <= S_PIN;
                  err_code_q <= '0;
                  lang_q     <= '0;
               end
            end
            S_PIN, S_MENU: begin
               if (!bus.card_in) begin
                  state_q <= S_IDLE;
               end else begin
                  if (any_acc) begin
                     timer_q <= '0;
                  end else if (expire) begin
                     timer_q    <= '0;
                     state_q    <= S_EJECT;
                     eject_q    <= 1'b1;
                     error_q    <= 1'b1;
                     err_code_q <= 3'd5;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end

                  if (lang_acc)
                     lang_q <= bus.lang_sel;

                  if (pin_acc) begin
                     if (pin_match) begin
                        state_q <= S_MENU;
                     end else if (tries_q == 4'(MAX_TRIES - 1)) begin
                        // Final miss reports only the retention, not another bad-PIN error.
                        state_q    <= S_RETAIN;
                        retain_q   <= 1'b1;
                        err_code_q <= 3'd7;
                     end else begin
                        tries_q    <= tries_q + 4'd1;
                        error_q    <= 1'b1;
                        err_code_q <= 3'd1;
                     end
                  end

                  if (op_acc) begin
                     case (bus.op_code)
                        2'b00: bal_vld_q <= 1'b1;
                        2'b01: begin
                           if (bus.amount == '0) begin
                              error_q    <= 1'b1;
                              err_code_q <= 3'd3;
                           end else if (bus.amount > bal_q) begin
                              error_q    <= 1'b1;
                              err_code_q <= 3'd2;
                           end else if (limit_hit) begin
                              error_q    <= 1'b1;
                              err_code_q <= 3'd6;
                           end else begin
                              bal_q      <= bal_q - bus.amount;
                              cash_amt_q <= bus.amount;
                              cash_vld_q <= 1'b1;
`ifdef ATM_SESSION_LIMIT_EN
                              wd_total_q <= wd_total_q + {1'b0, bus.amount};
`endif
                           end
                        end
                        2'b10: begin
                           if (bus.amount == '0) begin
                              error_q    <= 1'b1;
                              err_code_q <= 3'd3;
                           end else if (dep_sum[BAL_W]) begin
                              error_q    <= 1'b1;
                              err_code_q <= 3'd4;
                           end else begin
                              bal_q      <= dep_sum[BAL_W-1:0];
                              dep_done_q <= 1'b1;
                           end
                        end
                        default: begin
                           state_q <= S_EJECT;
                           eject_q <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_EJECT, S_RETAIN: begin
               if (!bus.card_in)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ready         = (state_q == S_IDLE);
   assign bus.state         = state_q;
   assign bus.cash_valid    = cash_vld_q;
   assign bus.cash_amount   = cash_amt_q;
   assign bus.deposit_done  = dep_done_q;
   assign bus.balance_valid = bal_vld_q;
   assign bus.balance       = bal_q;
   assign bus.card_eject    = eject_q;
   assign bus.card_retain   = retain_q;
   assign bus.error         = error_q;
   assign bus.err_code      = err_code_q;
   assign bus.language      = lang_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed test-plan scenarios, then randomized traffic,
// every cycle compared against a plain-arithmetic session model.
module tb_atm_session_ctrl;
   localparam int BAL_W = 16;
   localparam int PIN_W = 16;
   localparam int MAX_TRIES = 3;
   localparam int TIMEOUT_CYC = 255;
   localparam int INIT_BAL = 1000;
   localparam int WD_LIMIT = 500;
   localparam int BAL_MAX = (1 << BAL_W) - 1;
   localparam logic [15:0] GOOD_PIN = 16'h1234;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   atm_session_if #(.BAL_W(BAL_W), .PIN_W(PIN_W)) bus ();

   atm_session_ctrl #(
      .BAL_W(BAL_W), .PIN_W(PIN_W), .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC),
      .INIT_BAL(INIT_BAL), .WD_LIMIT(WD_LIMIT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Session model: state numbers, balance, tries and idle cycles as plain integers.
   int m_state, m_bal, m_cash, m_err, m_lang, m_tries, m_idle, m_total;
   bit e_cash, e_dep, e_balv, e_eject, e_retain, e_error;

   always @(posedge clk) begin
      int st;
      bit took;
      e_cash = 0; e_dep = 0; e_balv = 0; e_eject = 0; e_retain = 0; e_error = 0;
      if (reset) begin
         m_state = 0; m_bal = INIT_BAL; m_cash = 0; m_err = 0; m_lang = 0;
         m_tries = 0; m_idle = 0; m_total = 0;
      end else if (m_state == 0) begin
         m_tries = 0; m_idle = 0; m_total = 0;
         if (bus.card_in) begin m_state = 1; m_err = 0; m_lang = 0; end
      end else if (m_state == 3 || m_state == 4) begin
         if (!bus.card_in) m_state = 0;
      end else if (!bus.card_in) begin
         m_state = 0;
      end else begin
         st = m_state;
         took = (st == 1 && bus.pin_valid) || (st == 2 && bus.op_valid) || bus.lang_valid;
         if (bus.lang_valid) m_lang = int'(bus.lang_sel);
         if (st == 1 && bus.pin_valid) begin
            if (bus.pin_code == bus.card_pin) m_state = 2;
            else begin
               m_tries++;
               if (m_tries >= MAX_TRIES) begin m_state = 4; e_retain = 1; m_err = 7; end
               else begin e_error = 1; m_err = 1; end
            end
         end
         if (st == 2 && bus.op_valid) begin
            int amt;
            amt = int'(bus.amount);
            case (bus.op_code)
               2'd0: e_balv = 1;
               2'd1: begin
                  if (amt == 0) begin e_error = 1; m_err = 3; end
                  else if (amt > m_bal) begin e_error = 1; m_err = 2; end
`ifdef ATM_SESSION_LIMIT_EN
                  else if (m_total + amt > WD_LIMIT) begin e_error = 1; m_err = 6; end
`endif
                  else begin m_bal -= amt; m_cash = amt; e_cash = 1; m_total += amt; end
               end
               2'd2: begin
                  if (amt == 0) begin e_error = 1; m_err = 3; end
                  else if (m_bal + amt > BAL_MAX) begin e_error = 1; m_err = 4; end
                  else begin m_bal += amt; e_dep = 1; end
               end
               default: begin m_state = 3; e_eject = 1; end
            endcase
         end
         if (took) m_idle = 0;
         else begin
            m_idle++;
            if (m_idle >= TIMEOUT_CYC) begin
               m_state = 3; e_eject = 1; e_error = 1; m_err = 5; m_idle = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("state", 32'(bus.state), 32'(m_state));
         chk("ready", 32'(bus.ready), 32'(m_state == 0));
         chk("balance", 32'(bus.balance), 32'(m_bal));
         chk("cash_amount", 32'(bus.cash_amount), 32'(m_cash));
         chk("err_code", 32'(bus.err_code), 32'(m_err));
         chk("language", 32'(bus.language), 32'(m_lang));
         chk("cash_valid", 32'(bus.cash_valid), 32'(e_cash));
         chk("deposit_done", 32'(bus.deposit_done), 32'(e_dep));
         chk("balance_valid", 32'(bus.balance_valid), 32'(e_balv));
         chk("card_eject", 32'(bus.card_eject), 32'(e_eject));
         chk("card_retain", 32'(bus.card_retain), 32'(e_retain));
         chk("error", 32'(bus.error), 32'(e_error));
      end
   end

   // Inputs change only on the falling edge; each call spans one rising edge.
   task automatic step(input bit c, input bit pv, input logic [15:0] pc, input bit ov,
                       input logic [1:0] oc, input logic [15:0] amt, input bit lv,
                       input logic [1:0] ls);
      bus.card_in = c; bus.pin_valid = pv; bus.pin_code = pc;
      bus.op_valid = ov; bus.op_code = oc; bus.amount = amt;
      bus.lang_valid = lv; bus.lang_sel = ls;
      @(negedge clk);
   endtask

   task automatic idle(input bit c);
      step(c, 0, 16'd0, 0, 2'd0, 16'd0, 0, 2'd0);
   endtask

   task automatic op(input logic [1:0] oc, input logic [15:0] amt);
      step(1, 0, 16'd0, 1, oc, amt, 0, 2'd0);
   endtask

   task automatic pin(input logic [15:0] pc);
      step(1, 1, pc, 0, 2'd0, 16'd0, 0, 2'd0);
   endtask

   initial begin
      bus.card_pin = GOOD_PIN;
      reset = 1'b1;
      bus.card_in = 0; bus.pin_valid = 0; bus.pin_code = 0; bus.op_valid = 0;
      bus.op_code = 0; bus.amount = 0; bus.lang_valid = 0; bus.lang_sel = 0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_balance", 32'(bus.balance), 32'd1000);
      chk("rst_state", 32'(bus.state), 32'd0);
      reset = 1'b0;

      // Login and balance enquiry.
      idle(1);
      chk("lit_pin_state", 32'(bus.state), 32'd1);
      pin(GOOD_PIN);
      op(2'd0, 16'd0);
      chk("lit_balv", 32'(bus.balance_valid), 32'd1);
      chk("lit_bal1000", 32'(bus.balance), 32'd1000);
      chk("lit_menu", 32'(bus.state), 32'd2);

      op(2'd1, 16'd300);
      chk("lit_cashv", 32'(bus.cash_valid), 32'd1);
      chk("lit_cash300", 32'(bus.cash_amount), 32'd300);
      chk("lit_bal700", 32'(bus.balance), 32'd700);
      op(2'd1, 16'd800);
      chk("lit_err2", 32'(bus.err_code), 32'd2);
      chk("lit_bal700b", 32'(bus.balance), 32'd700);
      op(2'd2, 16'd65000);
      chk("lit_err4", 32'(bus.err_code), 32'd4);
      chk("lit_bal700c", 32'(bus.balance), 32'd700);
      op(2'd2, 16'd0);
      chk("lit_err3", 32'(bus.err_code), 32'd3);
      step(1, 0, 16'd0, 0, 2'd0, 16'd0, 1, 2'd2);
      chk("lit_lang", 32'(bus.language), 32'd2);
      op(2'd3, 16'd0);
      chk("lit_eject", 32'(bus.card_eject), 32'd1);
      idle(0);
      chk("lit_idle", 32'(bus.state), 32'd0);

      // Three wrong PINs.
      idle(1);
      pin(16'h0001);
      chk("lit_bad1", 32'({bus.error, bus.err_code}), 32'({1'b1, 3'd1}));
      pin(16'h0002);
      chk("lit_bad2", 32'({bus.error, bus.err_code}), 32'({1'b1, 3'd1}));
      pin(16'h0003);
      chk("lit_retain", 32'(bus.card_retain), 32'd1);
      chk("lit_err7", 32'(bus.err_code), 32'd7);
      chk("lit_retain_st", 32'(bus.state), 32'd4);
      idle(1);
      idle(0);
      chk("lit_idle2", 32'(bus.state), 32'd0);

      // Inactivity timeout in MENU.
      idle(1);
      pin(GOOD_PIN);
      repeat (TIMEOUT_CYC - 1) idle(1);
      chk("lit_pre_to", 32'(bus.state), 32'd2);
      idle(1);
      chk("lit_to_eject", 32'(bus.card_eject), 32'd1);
      chk("lit_err5", 32'(bus.err_code), 32'd5);
      idle(0);

      // Op on the expiry cycle wins.
      idle(1);
      pin(GOOD_PIN);
      repeat (TIMEOUT_CYC - 1) idle(1);
      op(2'd0, 16'd0);
      chk("lit_no_eject", 32'(bus.card_eject), 32'd0);
      chk("lit_balv2", 32'(bus.balance_valid), 32'd1);

      // Session withdrawal cap.
      op(2'd1, 16'd400);
      op(2'd1, 16'd200);
`ifdef ATM_SESSION_LIMIT_EN
      chk("lit_err6", 32'(bus.err_code), 32'd6);
      chk("lit_bal300", 32'(bus.balance), 32'd300);
`else
      chk("lit_bal100", 32'(bus.balance), 32'd100);
`endif
      idle(0);
      idle(1);
      pin(GOOD_PIN);
      op(2'd1, 16'd200);
`ifdef ATM_SESSION_LIMIT_EN
      chk("lit_new_sess", 32'(bus.cash_valid), 32'd1);
      chk("lit_bal100b", 32'(bus.balance), 32'd100);
`else
      chk("lit_err2b", 32'(bus.err_code), 32'd2);
`endif

      // Mid-session reset.
      reset = 1'b1;
      idle(1);
      chk("lit_mid_rst", 32'(bus.state), 32'd0);
      chk("lit_mid_rst_bal", 32'(bus.balance), 32'd1000);
      reset = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         int sel;
         logic [15:0] amt;
         sel = $urandom_range(0, 9);
         if (sel == 0) amt = 16'd0;
         else if (sel == 1) amt = 16'(BAL_MAX - $urandom_range(0, 100));
         else amt = 16'($urandom_range(1, 400));
         reset = ($urandom_range(0, 999) == 0);
         step($urandom_range(0, 99) < 96,
              $urandom_range(0, 99) < 30,
              ($urandom_range(0, 1) == 1) ? GOOD_PIN : 16'($urandom),
              $urandom_range(0, 99) < 40,
              2'($urandom_range(0, 3)),
              amt,
              $urandom_range(0, 99) < 10,
              2'($urandom_range(0, 3)));
      end
      reset = 1'b0;
      idle(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller: the next generation of the single-account ATM front end. It validates the card PIN with a bounded retry count, runs balance, withdraw, deposit and eject operations against a registered account balance, and enforces an inactivity timeout. It reports every result through one-cycle strobes and an error code. It sits between the card reader / keypad front end and the cash/deposit mechanism drivers.

## Interface
- BAL_W, 16, balance and amount width
- PIN_W, 16, PIN width
- MAX_TRIES, 3, wrong PINs before card retention (1..15)
- TIMEOUT_CYC, 255, idle cycles in PIN/MENU before forced eject (>=2)
- INIT_BAL, 1000, balance loaded at reset
- WD_LIMIT, 500, per-session withdrawal cap (only with ATM_SESSION_LIMIT_EN)

- clk  in  1  clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- card_in  in  1  card-present sensor level
- pin_valid  in  1  strobe: pin_code is valid
- pin_code  in  PIN_W  entered PIN
- card_pin  in  PIN_W  PIN read from card; stable while card_in=1
- op_valid  in  1  strobe: operation request
- op_code  in  2  00 balance, 01 withdraw, 10 deposit, 11 eject
- amount  in  BAL_W  operation amount
- lang_valid  in  1  strobe: language select
- lang_sel  in  2  requested language
- ready  out  1  high in IDLE
- state  out  3  current state encoding
- cash_valid  out  1  one-cycle dispense strobe
- cash_amount  out  BAL_W  amount to dispense, held until next dispense
- deposit_done  out  1  one-cycle deposit-accepted strobe
- balance_valid  out  1  one-cycle balance-report strobe
- balance  out  BAL_W  current registered account balance
- card_eject  out  1  one-cycle eject command
- card_retain  out  1  one-cycle retain command
- error  out  1  one-cycle error strobe
- err_code  out  3  last error; 0 none, 1 bad PIN, 2 insufficient, 3 zero amount, 4 overflow, 5 timeout, 6 limit, 7 retained
- language  out  2  active language

## Operation
- States: IDLE=0, PIN=1, MENU=2, EJECT=3, RETAIN=4.
- IDLE: card_in=1 -> PIN. On entry the controller clears the try counter, timer, session withdrawal total, err_code and language.
- PIN: pin_valid with pin_code==card_pin -> MENU. On mismatch: try counter +1, error=1, err_code=1. The MAX_TRIES-th mismatch -> RETAIN with err_code=7; no bad-PIN strobe on that cycle, only the retained strobe.
- MENU: op_valid accepted every cycle; back-to-back requests are legal.
  - balance: balance_valid=1.
  - withdraw: amount==0 -> err 3; amount>balance -> err 2; otherwise balance-=amount, cash_amount=amount, cash_valid=1.
  - deposit: amount==0 -> err 3; balance+amount > 2^BAL_W-1 -> err 4, balance unchanged; otherwise balance+=amount, deposit_done=1.
  - eject -> EJECT.
  - A rejected operation leaves the block in MENU and never changes balance.
- EJECT: card_eject=1 on the entry cycle; stays until card_in=0, then IDLE.
- RETAIN: card_retain=1 on the entry cycle; stays until card_in=0, then IDLE.
- card_in=0 in PIN or MENU: abort to IDLE next cycle; any request on that cycle is ignored.
- Timer: counts cycles in PIN/MENU and clears on any accepted pin_valid, op_valid or lang_valid. Reaching TIMEOUT_CYC -> EJECT with err 5.
- Priority: reset > card removal > accepted input > timeout. An input on the expiry cycle wins and clears the timer.
- lang_valid: updates language in PIN or MENU; ignored in other states.
- Balance persists across sessions; only reset reloads INIT_BAL. All arithmetic is BAL_W-bit with a carry/borrow check; results never wrap.

## Timing
- All outputs are registered. A request sampled on edge N produces its response strobe, updated balance and err_code after edge N, one cycle of latency.
- Strobes are exactly one cycle wide.
- Reset values: state=IDLE, ready=1, balance=INIT_BAL, cash_amount=0, language=0, err_code=0; all strobes 0.
- Reset asserted mid-session returns the block to IDLE on the next edge. No eject or retain strobe is issued.

## Configuration
- ATM_SESSION_LIMIT_EN defined: a withdrawal whose session total plus amount exceeds WD_LIMIT is rejected with err 6. The insufficient-funds check has precedence over the limit check. The session total clears in IDLE.
- ATM_SESSION_LIMIT_EN undefined: no total register and no limit check; err 6 is never produced.

## Test plan
- Reset, card_in=1, correct PIN, balance op -> state MENU, balance_valid pulse with balance=1000.
- Withdraw 300 then withdraw 800 -> first gives cash_valid with cash_amount=300 and balance=700; second gives err 2 with balance still 700.
- Deposit 65000 at balance 700 (BAL_W=16) -> err 4, balance 700; deposit 0 -> err 3.
- Three wrong PINs -> bad-PIN strobes on attempts 1 and 2, then card_retain pulse with err 7; card_in=0 -> IDLE.
- No input for 255 cycles in MENU -> card_eject pulse and err 5. An op on the expiry cycle instead prevents the eject.
- With ATM_SESSION_LIMIT_EN: withdraw 400 then 200 -> second rejected with err 6. Remove the card and start a new session, then withdraw 200 -> accepted.
